// File: rtl/perm_pkg.sv
// Shared types and constants for the permission-check arbiter: FSM states,
// port encoding, permission/fault bit positions and the latched request record.
package perm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Permission vector layout {X,W,R}
  localparam int PERM_R = 0;
  localparam int PERM_W = 1;
  localparam int PERM_X = 2;

  // Fault vector layout {bad_req, priv_rel, no_exec, wr_prot, no_read}
  localparam int FLT_NO_READ  = 0;
  localparam int FLT_WR_PROT  = 1;
  localparam int FLT_NO_EXEC  = 2;
  localparam int FLT_PRIV_REL = 3;
  localparam int FLT_BAD_REQ  = 4;

  localparam logic [7:0] FLT_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic       port;
    logic       req_r;
    logic       req_w;
    logic       req_x;
    logic       is_user;
    logic [2:0] u_perm;
    logic [2:0] s_perm;
    logic       tt_bypass;
  } req_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == FLT_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/perm_check.sv
// Combinational permission evaluator: maps one access (r/w/x one-hot, privilege,
// user/supervisor permissions, translation bypass) to allow and a fault vector.
module perm_check
  import perm_pkg::*;
(
  input  logic       req_r_i,
  input  logic       req_w_i,
  input  logic       req_x_i,
  input  logic       is_user_i,
  input  logic [2:0] u_perm_i,
  input  logic [2:0] s_perm_i,
  input  logic       tt_bypass_i,
  output logic       allow_o,
  output logic [4:0] fault_o
);

  logic [2:0] need;
  logic [2:0] eff;
  logic       one_hot;
  logic       user_denied;
  logic       sup_grants;

  always_comb begin
    need        = {req_x_i, req_w_i, req_r_i};
    eff         = is_user_i ? u_perm_i : s_perm_i;
    one_hot     = (need == 3'b001) || (need == 3'b010) || (need == 3'b100);
    user_denied = |(need & ~u_perm_i);
    sup_grants  = ((need & s_perm_i) == need);

    fault_o              = '0;
    fault_o[FLT_BAD_REQ] = ~one_hot;
    // Transparent translation skips the permission table, but a malformed
    // request is still reported.
    if (!tt_bypass_i) begin
      fault_o[FLT_NO_READ]  = need[PERM_R] & ~eff[PERM_R];
      fault_o[FLT_WR_PROT]  = need[PERM_W] & ~eff[PERM_W];
      fault_o[FLT_NO_EXEC]  = need[PERM_X] & ~eff[PERM_X];
      fault_o[FLT_PRIV_REL] = is_user_i & user_denied & sup_grants;
    end
    allow_o = (fault_o == 5'd0);
  end

endmodule

// File: rtl/perm_arbiter.sv
// Two-port (instruction/data) permission-check arbiter: round-robin grant,
// one shared checker, registered response and a sticky first-fault record.
module perm_arbiter
  import perm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,

  input  logic       i_req_valid,
  output logic       i_req_ready,
  input  logic       i_is_user,
  input  logic       i_tt_bypass,
  input  logic [2:0] i_u_perm,
  input  logic [2:0] i_s_perm,

  input  logic       d_req_valid,
  output logic       d_req_ready,
  input  logic       d_req_wr,
  input  logic       d_is_user,
  input  logic       d_tt_bypass,
  input  logic [2:0] d_u_perm,
  input  logic [2:0] d_s_perm,

  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_port,
  output logic       rsp_allow,
  output logic [4:0] rsp_fault,

  output logic       flt_valid,
  output logic       flt_port,
  output logic [4:0] flt_code,
  output logic       flt_ovf,
  output logic [7:0] flt_cnt,
  input  logic       flt_clear
);

  state_e     state_q;
  logic       last_grant_q;
  req_t       req_q;
  req_t       req_d;

  logic       rsp_valid_q;
  logic       rsp_port_q;
  logic       rsp_allow_q;
  logic [4:0] rsp_fault_q;

  logic       flt_valid_q, flt_valid_d;
  logic       flt_port_q,  flt_port_d;
  logic [4:0] flt_code_q,  flt_code_d;
  logic       flt_ovf_q,   flt_ovf_d;
  logic [7:0] flt_cnt_q,   flt_cnt_d;

  logic       grant_i;
  logic       grant_d;
  logic       accept;
  logic       chk_allow;
  logic [4:0] chk_fault;
  logic       chk_faulting;

  // Round-robin: on a tie the port not granted last wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (i_req_valid && d_req_valid) begin
        if (last_grant_q == PORT_D) grant_i = 1'b1;
        else                        grant_d = 1'b1;
      end else if (i_req_valid) begin
        grant_i = 1'b1;
      end else if (d_req_valid) begin
        grant_d = 1'b1;
      end
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;
  assign accept      = grant_i | grant_d;

  always_comb begin
    req_d = '0;
    if (grant_d) begin
      req_d.port      = PORT_D;
      req_d.req_r     = ~d_req_wr;
      req_d.req_w     = d_req_wr;
      req_d.req_x     = 1'b0;
      req_d.is_user   = d_is_user;
      req_d.u_perm    = d_u_perm;
      req_d.s_perm    = d_s_perm;
      req_d.tt_bypass = d_tt_bypass;
    end else begin
      req_d.port      = PORT_I;
      req_d.req_r     = 1'b0;
      req_d.req_w     = 1'b0;
      req_d.req_x     = 1'b1;
      req_d.is_user   = i_is_user;
      req_d.u_perm    = i_u_perm;
      req_d.s_perm    = i_s_perm;
      req_d.tt_bypass = i_tt_bypass;
    end
  end

  // Operand latch is pure data; its contents are only used while in CHECK.
  always_ff @(posedge clk) begin
    if (accept) req_q <= req_d;
  end

  perm_check u_check (
    .req_r_i     (req_q.req_r),
    .req_w_i     (req_q.req_w),
    .req_x_i     (req_q.req_x),
    .is_user_i   (req_q.is_user),
    .u_perm_i    (req_q.u_perm),
    .s_perm_i    (req_q.s_perm),
    .tt_bypass_i (req_q.tt_bypass),
    .allow_o     (chk_allow),
    .fault_o     (chk_fault)
  );

  assign chk_faulting = (state_q == ST_CHECK) && (chk_fault != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_D;
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_allow_q  <= 1'b0;
      rsp_fault_q  <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            last_grant_q <= grant_d ? PORT_D : PORT_I;
            state_q      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          rsp_valid_q <= 1'b1;
          rsp_port_q  <= req_q.port;
          rsp_allow_q <= chk_allow;
          rsp_fault_q <= chk_fault;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Clear is applied first so a fault on the same edge starts a fresh record.
  always_comb begin
    flt_valid_d = flt_valid_q;
    flt_port_d  = flt_port_q;
    flt_code_d  = flt_code_q;
    flt_ovf_d   = flt_ovf_q;
    flt_cnt_d   = flt_cnt_q;
    if (flt_clear) begin
      flt_valid_d = 1'b0;
      flt_ovf_d   = 1'b0;
      flt_cnt_d   = 8'd0;
    end
    if (chk_faulting) begin
      if (!flt_valid_d) begin
        flt_valid_d = 1'b1;
        flt_port_d  = req_q.port;
        flt_code_d  = chk_fault;
      end else begin
        flt_ovf_d   = 1'b1;
      end
      flt_cnt_d = sat_inc8(flt_cnt_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_valid_q <= 1'b0;
      flt_port_q  <= 1'b0;
      flt_code_q  <= 5'd0;
      flt_ovf_q   <= 1'b0;
      flt_cnt_q   <= 8'd0;
    end else begin
      flt_valid_q <= flt_valid_d;
      flt_port_q  <= flt_port_d;
      flt_code_q  <= flt_code_d;
      flt_ovf_q   <= flt_ovf_d;
      flt_cnt_q   <= flt_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_port  = rsp_port_q;
  assign rsp_allow = rsp_allow_q;
  assign rsp_fault = rsp_fault_q;
  assign flt_valid = flt_valid_q;
  assign flt_port  = flt_port_q;
  assign flt_code  = flt_code_q;
  assign flt_ovf   = flt_ovf_q;
  assign flt_cnt   = flt_cnt_q;

endmodule

// File: tb/tb_perm_arbiter.sv
// Directed bench for perm_arbiter: latency, round-robin, fault record,
// back-pressure, bypass, counter saturation and mid-transaction reset.
module tb_perm_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req_valid, i_req_ready, i_is_user, i_tt_bypass;
  logic [2:0] i_u_perm, i_s_perm;
  logic       d_req_valid, d_req_ready, d_req_wr, d_is_user, d_tt_bypass;
  logic [2:0] d_u_perm, d_s_perm;
  logic       rsp_valid, rsp_ready, rsp_port, rsp_allow;
  logic [4:0] rsp_fault;
  logic       flt_valid, flt_port, flt_ovf, flt_clear;
  logic [4:0] flt_code;
  logic [7:0] flt_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perm_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
    .i_is_user(i_is_user), .i_tt_bypass(i_tt_bypass),
    .i_u_perm(i_u_perm), .i_s_perm(i_s_perm),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_wr(d_req_wr),
    .d_is_user(d_is_user), .d_tt_bypass(d_tt_bypass),
    .d_u_perm(d_u_perm), .d_s_perm(d_s_perm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
    .rsp_allow(rsp_allow), .rsp_fault(rsp_fault),
    .flt_valid(flt_valid), .flt_port(flt_port), .flt_code(flt_code),
    .flt_ovf(flt_ovf), .flt_cnt(flt_cnt), .flt_clear(flt_clear)
  );

  task automatic idle_inputs();
    i_req_valid = 0; i_is_user = 0; i_tt_bypass = 0; i_u_perm = 0; i_s_perm = 0;
    d_req_valid = 0; d_req_wr = 0; d_is_user = 0; d_tt_bypass = 0; d_u_perm = 0; d_s_perm = 0;
    rsp_ready = 0; flt_clear = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Presents one request and returns at #1 after the accepting edge (FSM in CHECK).
  task automatic issue(input logic port, input logic wr, input logic user,
                       input logic [2:0] u, input logic [2:0] s, input logic tt,
                       output bit ok);
    ok = 0;
    if (port == 1'b0) begin
      i_req_valid = 1; i_is_user = user; i_u_perm = u; i_s_perm = s; i_tt_bypass = tt;
    end else begin
      d_req_valid = 1; d_req_wr = wr; d_is_user = user; d_u_perm = u; d_s_perm = s; d_tt_bypass = tt;
    end
    #1;
    for (int n = 0; n < 20 && !ok; n++) begin
      if ((port == 1'b0 && i_req_ready) || (port == 1'b1 && d_req_ready)) ok = 1;
      @(posedge clk); #1;
    end
    i_req_valid = 0; d_req_valid = 0;
  endtask

  task automatic ack();
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_req_valid = 1; d_req_valid = 1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {i_req_ready, d_req_ready});
    end
    checks++;
    if ({rsp_valid, rsp_port, rsp_allow, rsp_fault} !== 8'h00) begin
      errors++; $display("FAIL reset_rsp: got v=%b p=%b a=%b f=%b want all 0", rsp_valid, rsp_port, rsp_allow, rsp_fault);
    end
    checks++;
    if ({flt_valid, flt_port, flt_code, flt_ovf, flt_cnt} !== 16'h0000) begin
      errors++; $display("FAIL reset_flt: got v=%b p=%b c=%b o=%b n=%0d want all 0", flt_valid, flt_port, flt_code, flt_ovf, flt_cnt);
    end
    i_req_valid = 0; d_req_valid = 0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_i_exec();
    bit ok;
    i_req_valid = 1; i_is_user = 1; i_u_perm = 3'b100; i_s_perm = 3'b000; i_tt_bypass = 0;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      errors++; $display("FAIL iexec_grant: got %b want 10", {i_req_ready, d_req_ready});
    end
    @(posedge clk); #1;
    i_req_valid = 0;
    checks++;
    if ({rsp_valid, i_req_ready, d_req_ready} !== 3'b000) begin
      errors++; $display("FAIL iexec_check_cycle: got v/ri/rd=%b want 000", {rsp_valid, i_req_ready, d_req_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_port, rsp_allow, rsp_fault} !== {3'b101, 5'b00000}) begin
      errors++; $display("FAIL iexec_rsp: got v=%b p=%b a=%b f=%b want v=1 p=0 a=1 f=00000", rsp_valid, rsp_port, rsp_allow, rsp_fault);
    end
    checks++;
    if (flt_valid !== 1'b0 || flt_cnt !== 8'd0) begin
      errors++; $display("FAIL iexec_noflt: got fv=%b cnt=%0d want 0 0", flt_valid, flt_cnt);
    end
    ack();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL iexec_ack: got rsp_valid=%b want 0", rsp_valid);
    end
    ok = 1;
  endtask

  task automatic test_round_robin();
    int  grants;
    logic exp_port;
    do_reset();
    rsp_ready = 1;
    i_req_valid = 1; i_is_user = 1; i_u_perm = 3'b100; i_s_perm = 3'b000; i_tt_bypass = 0;
    d_req_valid = 1; d_req_wr = 0; d_is_user = 1; d_u_perm = 3'b001; d_s_perm = 3'b000; d_tt_bypass = 0;
    #1;
    grants = 0;
    for (int c = 0; c < 60 && grants < 8; c++) begin
      if (i_req_ready && d_req_ready) begin
        checks++; errors++;
        $display("FAIL rr_both_ready: cycle %0d got both readies 1 want at most one", c);
      end else if (i_req_ready || d_req_ready) begin
        exp_port = grants[0];
        checks++;
        if (d_req_ready !== exp_port) begin
          errors++; $display("FAIL rr_grant%0d: got port %b want %b", grants, d_req_ready, exp_port);
        end
        grants++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (grants != 8) begin
      errors++; $display("FAIL rr_count: got %0d grants want 8", grants);
    end
    i_req_valid = 0; d_req_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    rsp_ready = 0;
  endtask

  task automatic test_fault_capture();
    bit ok;
    do_reset();
    issue(1'b1, 1'b1, 1'b1, 3'b001, 3'b010, 1'b0, ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || {rsp_valid, rsp_port, rsp_allow, rsp_fault} !== {3'b110, 5'b01010}) begin
      errors++; $display("FAIL dwr_rsp: got ok=%0d v=%b p=%b a=%b f=%b want v=1 p=1 a=0 f=01010", ok, rsp_valid, rsp_port, rsp_allow, rsp_fault);
    end
    checks++;
    if ({flt_valid, flt_port, flt_code, flt_ovf, flt_cnt} !== {2'b11, 5'b01010, 1'b0, 8'd1}) begin
      errors++; $display("FAIL dwr_flt: got v=%b p=%b c=%b o=%b n=%0d want 1 1 01010 0 1", flt_valid, flt_port, flt_code, flt_ovf, flt_cnt);
    end
    ack();
  endtask

  task automatic test_overflow();
    bit ok;
    issue(1'b0, 1'b0, 1'b1, 3'b000, 3'b100, 1'b0, ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || rsp_fault !== 5'b01100 || rsp_allow !== 1'b0) begin
      errors++; $display("FAIL ovf_rsp: got ok=%0d a=%b f=%b want a=0 f=01100", ok, rsp_allow, rsp_fault);
    end
    checks++;
    if ({flt_valid, flt_port, flt_code, flt_ovf, flt_cnt} !== {2'b11, 5'b01010, 1'b1, 8'd2}) begin
      errors++; $display("FAIL ovf_flt: got v=%b p=%b c=%b o=%b n=%0d want 1 1 01010 1 2", flt_valid, flt_port, flt_code, flt_ovf, flt_cnt);
    end
    ack();
    issue(1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, ok);
    flt_clear = 1;
    @(posedge clk); #1;
    flt_clear = 0;
    checks++;
    if (!ok || {flt_valid, flt_port, flt_code, flt_ovf, flt_cnt} !== {2'b11, 5'b00001, 1'b0, 8'd1}) begin
      errors++; $display("FAIL clr_fault: got ok=%0d v=%b p=%b c=%b o=%b n=%0d want 1 1 00001 0 1", ok, flt_valid, flt_port, flt_code, flt_ovf, flt_cnt);
    end
    ack();
  endtask

  task automatic test_backpressure();
    bit ok;
    issue(1'b1, 1'b0, 1'b1, 3'b001, 3'b000, 1'b0, ok);
    @(posedge clk); #1;
    i_req_valid = 1; d_req_valid = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (!ok || {rsp_valid, rsp_port, rsp_allow, rsp_fault, i_req_ready, d_req_ready} !== {3'b111, 5'b00000, 2'b00}) begin
        errors++; $display("FAIL hold%0d: got v=%b p=%b a=%b f=%b ri=%b rd=%b want 1 1 1 00000 0 0", c, rsp_valid, rsp_port, rsp_allow, rsp_fault, i_req_ready, d_req_ready);
      end
      @(posedge clk); #1;
    end
    i_req_valid = 0; d_req_valid = 0;
    ack();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: got rsp_valid=%b want 0", rsp_valid);
    end
    issue(1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1, ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || {rsp_valid, rsp_allow, rsp_fault} !== {2'b11, 5'b00000}) begin
      errors++; $display("FAIL tt_rsp: got ok=%0d v=%b a=%b f=%b want 1 1 00000", ok, rsp_valid, rsp_allow, rsp_fault);
    end
    checks++;
    if ({flt_code, flt_ovf, flt_cnt} !== {5'b00001, 1'b0, 8'd1}) begin
      errors++; $display("FAIL tt_noflt: got c=%b o=%b n=%0d want 00001 0 1", flt_code, flt_ovf, flt_cnt);
    end
    ack();
  endtask

  task automatic test_saturation();
    bit ok;
    int lost;
    flt_clear = 1;
    @(posedge clk); #1;
    flt_clear = 0;
    checks++;
    if ({flt_valid, flt_ovf, flt_cnt} !== 10'd0) begin
      errors++; $display("FAIL clear_only: got v=%b o=%b n=%0d want 0 0 0", flt_valid, flt_ovf, flt_cnt);
    end
    lost = 0;
    for (int k = 0; k < 256; k++) begin
      issue(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, ok);
      if (!ok) lost++;
      @(posedge clk); #1;
      ack();
    end
    checks++;
    if (lost != 0 || {flt_valid, flt_port, flt_code, flt_ovf, flt_cnt} !== {2'b10, 5'b00100, 1'b1, 8'd255}) begin
      errors++; $display("FAIL sat: got lost=%0d v=%b p=%b c=%b o=%b n=%0d want 0 1 0 00100 1 255", lost, flt_valid, flt_port, flt_code, flt_ovf, flt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    issue(1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0, ok);
    rst = 1'b1;
    #2;
    @(posedge clk); #1;
    checks++;
    if (!ok || {rsp_valid, rsp_allow, rsp_fault, flt_valid, flt_ovf, flt_cnt} !== 17'd0) begin
      errors++; $display("FAIL rstmid: got ok=%0d v=%b a=%b f=%b fv=%b o=%b n=%0d want all 0", ok, rsp_valid, rsp_allow, rsp_fault, flt_valid, flt_ovf, flt_cnt);
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rsp_valid || flt_valid || flt_cnt != 0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rstmid_after: got %0d cycles with response/fault activity want 0", seen);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #1;
    test_reset();
    test_i_exec();
    test_round_robin();
    test_fault_capture();
    test_overflow();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
